// File: rtl/board_io_pkg.sv
// board_io_pkg: debounce length defaults for the board input conditioner at common system clocks
package board_io_pkg;

    localparam int unsigned DebounceMs = 10;
    localparam int unsigned DebounceCycles50MHz = 500_000;
    localparam int unsigned DebounceCycles100MHz = 1_000_000;

    function automatic int unsigned debounce_cycles(input int unsigned clk_khz, input int unsigned ms);
        return clk_khz * ms;
    endfunction

endpackage

// File: rtl/board_input_debounce_chan.sv
// board_input_debounce_chan: one input channel of synchroniser, debounce counter, stable-level edges and sticky event
module board_input_debounce_chan
    import board_io_pkg::*;
#(
    parameter int unsigned DebounceCycles = DebounceCycles50MHz,
    parameter int unsigned CntWidth = $clog2(DebounceCycles + 1)
) (
    input  logic clk_sys_i,
    input  logic rst_sys_ni,
    input  logic raw_i,
    input  logic event_clr_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o,
    output logic event_o
);

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);

    logic sync1_q, sync_q, stable_q, rise_q, fall_q, event_q;
    logic [CntWidth-1:0] cnt_q;
    logic differ, flip;

    assign differ = sync_q != stable_q;
    assign flip = differ && cnt_q == CntMax;

    // rise/fall are registered alongside stable_q so they coincide with the new level
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sync1_q  <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            event_q  <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync_q   <= sync1_q;
            cnt_q    <= (differ && !flip) ? cnt_q + 1'b1 : '0;
            stable_q <= flip ? sync_q : stable_q;
            rise_q   <= flip & sync_q;
            fall_q   <= flip & ~sync_q;
            event_q  <= rise_q | fall_q | (event_q & ~event_clr_i);
        end
    end

    assign stable_o = stable_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign event_o = event_q;

endmodule

// File: rtl/board_input_conditioner.sv
// board_input_conditioner: per-channel debounced board inputs with polarity, edge pulses, sticky events and interrupt
module board_input_conditioner
    import board_io_pkg::*;
#(
    parameter int unsigned NumIn = 8,
    parameter int unsigned DebounceCycles = DebounceCycles50MHz,
    parameter logic [NumIn-1:0] InvertMask = '0,
    localparam int unsigned CntWidth = $clog2(DebounceCycles + 1)
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [NumIn-1:0] raw_i,
    output logic [NumIn-1:0] level_o,
    output logic [NumIn-1:0] rise_o,
    output logic [NumIn-1:0] fall_o,
    output logic [NumIn-1:0] event_o,
    input  logic [NumIn-1:0] event_clr_i,
    input  logic [NumIn-1:0] irq_en_i,
    output logic             irq_o
);

    logic [NumIn-1:0] stable, stable_rise, stable_fall;
    logic irq_q;

    for (genvar i = 0; i < NumIn; i++) begin : g_chan
        board_input_debounce_chan #(
            .DebounceCycles(DebounceCycles),
            .CntWidth      (CntWidth)
        ) u_chan (
            .clk_sys_i  (clk_sys_i),
            .rst_sys_ni (rst_sys_ni),
            .raw_i      (raw_i[i]),
            .event_clr_i(event_clr_i[i]),
            .stable_o   (stable[i]),
            .rise_o     (stable_rise[i]),
            .fall_o     (stable_fall[i]),
            .event_o    (event_o[i])
        );
    end

    // inversion swaps which stable transition is a rise of the output level
    assign level_o = stable ^ InvertMask;
    assign rise_o = (stable_rise & ~InvertMask) | (stable_fall & InvertMask);
    assign fall_o = (stable_fall & ~InvertMask) | (stable_rise & InvertMask);

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) irq_q <= 1'b0;
        else irq_q <= |(event_o & irq_en_i);
    end

    assign irq_o = irq_q;

endmodule

// File: doc/board_input_conditioner.md
Name: board_input_conditioner

Overview:
- Parametrised conditioning block for raw board inputs (switches, buttons) before they enter the demo system GPI path.
- Per channel:
  - 2-FF synchroniser
  - counter-based debouncer
  - optional polarity inversion
  - one-cycle rise/fall pulses
  - sticky event flags with clear and a masked interrupt.
- Sits between the board input pins and the system's general-purpose inputs.
- Replaces direct pin-to-GPI wiring and scales to any channel count.

Parameters:
- NumIn, 8, number of input channels.
- DebounceCycles, 500_000, cycles the synchronised input must differ from the stable level before the stable level flips (10 ms at 50 MHz). Must be ≥1.
- InvertMask, '0 (NumIn bits), per-channel inversion applied to level_o only. Edges refer to the inverted level.
- CntWidth, $clog2(DebounceCycles+1), derived; not to be overridden.

Ports:
- clk_sys_i  input  1  system clock.
- rst_sys_ni  input  1  asynchronous active-low reset.
- raw_i  input  NumIn  asynchronous raw board inputs.
- level_o  output  NumIn  debounced level (stable ^ InvertMask).
- rise_o  output  NumIn  one-cycle pulse on level_o 0→1.
- fall_o  output  NumIn  one-cycle pulse on level_o 1→0.
- event_o  output  NumIn  sticky flag: any edge since last clear.
- event_clr_i  input  NumIn  per-channel clear of event_o.
- irq_en_i  input  NumIn  per-channel interrupt enable.
- irq_o  output  1  |(event_o & irq_en_i), registered.

Behaviour:
- Interface: one clock (clk_sys_i); reset rst_sys_ni is asynchronous and active-low.
- Reset values:
  - sync flops, stable, counters, event, rise, fall, irq_o: all 0.
  - level_o = InvertMask.
- Synchroniser: raw_i → sync1_q → sync_q. raw_i is never used combinationally.
- Debounce, per channel, each cycle:
  - sync_q == stable_q: cnt_q ← 0.
  - sync_q != stable_q and cnt_q < DebounceCycles-1: cnt_q ← cnt_q+1.
  - sync_q != stable_q and cnt_q == DebounceCycles-1: stable_q ← sync_q, cnt_q ← 0.
- Latency: a raw change held steady shows on level_o exactly 2+DebounceCycles clock edges after first being sampled.
- Glitch rejection: a glitch whose sync_q excursion lasts < DebounceCycles cycles produces no level change, and the counter restarts from 0.
- DebounceCycles=1: stable follows sync_q with one cycle of delay.
- Edge pulses:
  - rise_o/fall_o are registered and asserted in the same cycle level_o first shows the new value.
  - Each pulse lasts exactly one cycle.
  - rise_o and fall_o are never both high for one channel.
- Sticky event:
  - set on rise_o|fall_o (visible the cycle after the pulse).
  - cleared by event_clr_i.
  - simultaneous set and clear in one cycle: set wins.
- irq_o: registered from the event_o & irq_en_i reduction, one cycle after event_o.
- Counter is sized so DebounceCycles-1 never overflows CntWidth. No wrap is possible.
- Input held high through reset release: channel debounces from stable=0 and produces one rise_o after 2+DebounceCycles cycles. This is intended power-on behaviour.
- Reset asserted mid-count: every register is cleared immediately. No pulse is emitted on release.
- Channels are fully independent; no shared counter.

Decomposition:
- board_io_pkg holds DebounceCycles defaults per clock frequency (50 MHz, 100 MHz).
- No typedefs are needed.
- One natural sub-module: board_input_debounce_chan.
  - Contains the synchroniser, counter, stable, rise/fall and event flop for one channel.
  - Generated NumIn times.
- The top level handles InvertMask and irq_o.

Test Plan:
- Reset, NumIn=4, DebounceCycles=4, raw_i=0 → after release, level_o=InvertMask, no pulses, irq_o=0.
- raw_i[0] 0→1 held → level_o[0]=1 exactly 6 edges after first sample; rise_o[0] single-cycle pulse that cycle; event_o[0]=1 next cycle.
- raw_i[1] 3-cycle high glitch with DebounceCycles=4 → level_o, rise_o, event_o unchanged. A 4-cycle high glitch → rise after 6 edges, then fall 6 edges after the return to 0.
- InvertMask=4'b0100, raw_i[2] 0→1 → level_o[2] 1→0 with fall_o[2] pulse.
- event_o[3] set, irq_en_i=4'b1000 → irq_o=1 one cycle later. event_clr_i[3] pulse → event_o[3]=0, irq_o=0 next cycle. Clear coincident with a new edge → event_o[3] stays 1.
- Reset asserted at cnt_q=2 → all outputs return to reset values immediately, no pulse after release. Raw held high at release → one rise after 6 edges.
